// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one log2 stage per register, SLL/SRL/SRA/ROR.
// Whole-pipe stall on backpressure; bubbles carry zero data.
module shifter_pipe #(
   parameter  int N = 32,
   localparam int S = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [S-1:0] shamt,
   input  logic [1:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         y_zero
);

   logic w_adv;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   genvar k;
   for (k = 0; k < S; k++) begin : g_st
      localparam int D = 1 << k;

      logic                w_vin;
      logic [N-1:0]        w_din;
      logic [1:0]          w_opin;
      logic [S-k-1:0]      w_shin;
      logic [N-1:0]        w_dsh;
      logic signed [N-1:0] w_sdin;
      logic                r_vld;
      logic [N-1:0]        r_d;

      if (k == 0) begin : g_src
         // Bubbles enter as all-zero so idle stages never expose stale data
         assign w_vin  = in_valid;
         assign w_din  = in_valid ? a : '0;
         assign w_opin = in_valid ? op : 2'b00;
         assign w_shin = in_valid ? shamt : '0;
      end else begin : g_src
         assign w_vin  = g_st[k-1].r_vld;
         assign w_din  = g_st[k-1].r_d;
         assign w_opin = g_st[k-1].g_fwd.r_op;
         assign w_shin = g_st[k-1].g_fwd.r_sh;
      end

      assign w_sdin = w_din;

      always_comb begin
         w_dsh = w_din;
         if (w_shin[0]) begin
            unique case (w_opin)
               2'b00:   w_dsh = w_din << D;
               2'b01:   w_dsh = w_din >> D;
               2'b10:   w_dsh = w_sdin >>> D;
               default: w_dsh = (w_din >> D) | (w_din << (N - D));
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            r_vld <= 1'b0;
            r_d   <= '0;
         end else if (w_adv) begin
            r_vld <= w_vin;
            r_d   <= w_dsh;
         end
      end

      // Last stage has no remaining shift bits and no consumer of op
      if (k < S - 1) begin : g_fwd
         logic [1:0]     r_op;
         logic [S-k-2:0] r_sh;

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_op <= 2'b00;
               r_sh <= '0;
            end else if (w_adv) begin
               r_op <= w_opin;
               r_sh <= w_shin[S-k-1:1];
            end
         end
      end
   end

   assign out_valid = g_st[S-1].r_vld;
   assign y         = g_st[S-1].r_d;
   assign y_zero    = out_valid && (y == '0);

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed + randomized bench for shifter_pipe at N = 8.
module tb_shifter_pipe;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [2:0] shamt;
   logic [1:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       y_zero;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;
   logic [7:0] q[$];
   logic [7:0] y_hold;

   always #5 clk = ~clk;

   shifter_pipe #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_zero    (y_zero)
   );

   function automatic logic [7:0] ref_f(input logic [7:0] x,
                                        input logic [2:0] s,
                                        input logic [1:0] o);
      logic signed [7:0] t;
      logic [15:0]       d;
      t = x;
      d = {x, x} >> s;
      case (o)
         2'b00:   return x << s;
         2'b01:   return x >> s;
         2'b10:   return t >>> s;
         default: return d[7:0];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check outputs, track accepts/drains.
   task automatic step(input logic iv, input logic [7:0] av,
                       input logic [2:0] sh, input logic [1:0] o,
                       input logic ordy);
      in_valid  = iv;
      a         = av;
      shamt     = sh;
      op        = o;
      out_ready = ordy;
      #1;
      chk("in_ready", in_ready, !out_valid || ordy);
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("stale", out_valid, 0);
         end else begin
            chk("y", y, q[0]);
            chk("y_zero", y_zero, q[0] == 8'h00);
            if (ordy) begin
               void'(q.pop_front());
               n_out++;
            end
         end
      end else begin
         chk("y_zero_idle", y_zero, 0);
      end
      if (iv && in_ready) q.push_back(ref_f(av, sh, o));
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++)
         step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      chk("drain_empty", q.size(), 0);
   endtask

   // Single op with exact latency check: valid after the 3rd edge.
   task automatic single(input logic [7:0] av, input logic [2:0] sh,
                         input logic [1:0] o, input logic [7:0] ey,
                         input string tag);
      in_valid  = 1'b1;
      a         = av;
      shamt     = sh;
      op        = o;
      out_ready = 1'b1;
      #1 chk({tag, "_acc"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~av;
      shamt    = ~sh;
      op       = ~o;
      chk({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_lat2"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_lat3"}, out_valid, 1);
      chk({tag, "_y"}, y, ey);
      chk({tag, "_yz"}, y_zero, ey == 8'h00);
      @(negedge clk);
      chk({tag, "_gone"}, out_valid, 0);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b1;
      a         = 8'hFF;
      shamt     = 3'd1;
      op        = 2'b00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("rst_ov", out_valid, 0);
      chk("rst_y", y, 8'h00);
      chk("rst_yz", y_zero, 0);
      chk("rst_ir", in_ready, 1);
      @(negedge clk);
      chk("rst_ov2", out_valid, 0);
      rst = 1'b1;

      single(8'hB1, 3'd3, 2'b00, 8'h88, "sll");
      single(8'h90, 3'd2, 2'b10, 8'hE4, "sra");
      single(8'hF0, 3'd7, 2'b01, 8'h01, "srl7");
      single(8'h81, 3'd1, 2'b11, 8'hC0, "ror1");
      single(8'h01, 3'd1, 2'b01, 8'h00, "srl_z");
      single(8'hA5, 3'd0, 2'b10, 8'hA5, "sra0");
      single(8'h3C, 3'd7, 2'b11, 8'h78, "ror7");
      single(8'h6B, 3'd5, 2'b10, 8'h03, "sra_pos");

      n_out = 0;
      for (int i = 0; i < 11; i++) begin
         if (i < 8)
            step(1'b1, 8'h11 * (i + 1), 3'(i), 2'(i), 1'b1);
         else
            step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
         if (i == 2) chk("b2b_none_yet", n_out, 0);
         if (i == 7) chk("b2b_mid", n_out, 5);
      end
      chk("b2b_count", n_out, 8);
      chk("b2b_empty", q.size(), 0);
      #1 chk("b2b_idle", out_valid, 0);

      n_out = 0;
      for (int i = 0; i < 6; i++)
         step(1'b1, 8'hC3 ^ 8'(i * 37), 3'(i + 1), 2'(i + 2), 1'b1);
      #1 y_hold = y;
      chk("bp_pre_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_hold_y", y, y_hold);
         chk("bp_hold_v", out_valid, 1);
         step(1'b1, 8'hEE, 3'd4, 2'b01, 1'b0);
      end
      drain();
      chk("bp_count", n_out, 6);

      for (int i = 0; i < 3; i++)
         step(1'b1, 8'h80 | 8'(i), 3'd1, 2'b10, 1'b0);
      rst      = 1'b0;
      in_valid = 1'b1;
      a        = 8'h55;
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      q.delete();
      #1;
      chk("mrst_ov", out_valid, 0);
      chk("mrst_y", y, 8'h00);
      chk("mrst_yz", y_zero, 0);
      for (int i = 0; i < 5; i++) begin
         #1 chk("mrst_flush", out_valid, 0);
         step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      end

      for (int i = 0; i < 10000; i++)
         step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom),
              2'($urandom), $urandom_range(0, 3) != 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
